// File: rtl/axi_native_master.sv
// -----------------------------------------------------------------------------
// axi_native_master
//
// Bridges a simple native request/response port onto a single-beat AXI4
// master. Only one transaction is in flight at a time. A request whose byte
// strobes are non-zero becomes an AXI write; a request with all strobes zero
// becomes an AXI read. Each completed transaction produces a one-cycle pulse
// on rsp_valid_o.
//
// Every output comes straight from a flop, so no input reaches an output
// within the same cycle.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_*                 native request: valid/ready handshake, byte
//                         address, write data, byte strobes (zero = read)
//   rsp_*                 native response: one-cycle valid pulse, read data,
//                         error flag (non-zero bresp/rresp)
//   axi_aw* / axi_w* / axi_b*   AXI write address, write data, write response
//   axi_ar* / axi_r*            AXI read address, read data
// -----------------------------------------------------------------------------
module axi_native_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8,
    parameter int LEN_WIDTH  = 8,
    parameter int AXI_ID     = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    // native request
    input  logic                  req_valid_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [STRB_WIDTH-1:0] req_wstrb_i,
    output logic                  req_ready_o,
    // native response
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    // AXI write address
    output logic [ID_WIDTH-1:0]   axi_awid_o,
    output logic [ADDR_WIDTH-1:0] axi_awaddr_o,
    output logic [LEN_WIDTH-1:0]  axi_awlen_o,
    output logic [2:0]            axi_awsize_o,
    output logic [1:0]            axi_awburst_o,
    output logic [1:0]            axi_awlock_o,
    output logic [3:0]            axi_awcache_o,
    output logic [2:0]            axi_awprot_o,
    output logic [3:0]            axi_awqos_o,
    output logic                  axi_awvalid_o,
    input  logic                  axi_awready_i,
    // AXI write data / response
    output logic [DATA_WIDTH-1:0] axi_wdata_o,
    output logic [STRB_WIDTH-1:0] axi_wstrb_o,
    output logic                  axi_wlast_o,
    output logic                  axi_wvalid_o,
    input  logic                  axi_wready_i,
    input  logic [ID_WIDTH-1:0]   axi_bid_i,
    input  logic [1:0]            axi_bresp_i,
    input  logic                  axi_bvalid_i,
    output logic                  axi_bready_o,
    // AXI read address
    output logic [ID_WIDTH-1:0]   axi_arid_o,
    output logic [ADDR_WIDTH-1:0] axi_araddr_o,
    output logic [LEN_WIDTH-1:0]  axi_arlen_o,
    output logic [2:0]            axi_arsize_o,
    output logic [1:0]            axi_arburst_o,
    output logic [1:0]            axi_arlock_o,
    output logic [3:0]            axi_arcache_o,
    output logic [2:0]            axi_arprot_o,
    output logic [3:0]            axi_arqos_o,
    output logic                  axi_arvalid_o,
    input  logic                  axi_arready_i,
    // AXI read data
    input  logic [ID_WIDTH-1:0]   axi_rid_i,
    input  logic [DATA_WIDTH-1:0] axi_rdata_i,
    input  logic [1:0]            axi_rresp_i,
    input  logic                  axi_rlast_i,
    input  logic                  axi_rvalid_i,
    output logic                  axi_rready_o
);

    localparam int ADDR_OFFS = $clog2(STRB_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA
    } state_t;

    state_t                  state_reg;
    logic                    req_ready_reg;
    logic                    rsp_valid_reg;
    logic                    rsp_err_reg;
    logic [DATA_WIDTH-1:0]   rsp_rdata_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    logic [STRB_WIDTH-1:0]   wstrb_reg;
    logic                    awvalid_reg;
    logic                    wvalid_reg;
    logic                    bready_reg;
    logic                    arvalid_reg;
    logic                    rready_reg;

    // Bus-aligned request address: the sub-word offset bits are dropped,
    // the strobes already say which bytes matter.
    logic [ADDR_WIDTH-1:0]   addr_aligned;

    genvar gi;
    generate
        for (gi = 0; gi < ADDR_WIDTH; gi++) begin : g_align
            if (gi < ADDR_OFFS) begin : g_zero
                assign addr_aligned[gi] = 1'b0;
            end else begin : g_keep
                assign addr_aligned[gi] = req_addr_i[gi];
            end
        end
    endgenerate

    // IDs are not checked (single outstanding transaction), and the address
    // offset bits are discarded by the alignment above.
    logic unused_inputs;
    assign unused_inputs = ^{axi_bid_i, axi_rid_i, req_addr_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            req_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
            awvalid_reg   <= 1'b0;
            wvalid_reg    <= 1'b0;
            bready_reg    <= 1'b0;
            arvalid_reg   <= 1'b0;
            rready_reg    <= 1'b0;
        end else begin
            rsp_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    req_ready_reg <= 1'b1;
                    if (req_valid_i && req_ready_reg) begin
                        req_ready_reg <= 1'b0;
                        addr_reg      <= addr_aligned;
                        wdata_reg     <= req_wdata_i;
                        wstrb_reg     <= req_wstrb_i;
                        if (|req_wstrb_i) begin
                            state_reg   <= WR_ADDR_DATA;
                            awvalid_reg <= 1'b1;
                            wvalid_reg  <= 1'b1;
                        end else begin
                            state_reg   <= RD_ADDR;
                            arvalid_reg <= 1'b1;
                        end
                    end
                end
                WR_ADDR_DATA: begin
                    // AW and W retire independently; a channel whose valid
                    // is already low has finished its handshake earlier.
                    if (awvalid_reg && axi_awready_i) begin
                        awvalid_reg <= 1'b0;
                    end
                    if (wvalid_reg && axi_wready_i) begin
                        wvalid_reg <= 1'b0;
                    end
                    if ((!awvalid_reg || axi_awready_i) &&
                        (!wvalid_reg  || axi_wready_i)) begin
                        state_reg  <= WR_RESP;
                        bready_reg <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (axi_bvalid_i) begin
                        bready_reg    <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= |axi_bresp_i;
                        req_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                RD_ADDR: begin
                    if (axi_arready_i) begin
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                        state_reg   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    // Beats without rlast cannot occur for len=0 and are
                    // simply consumed.
                    if (axi_rvalid_i && axi_rlast_i) begin
                        rready_reg    <= 1'b0;
                        rsp_rdata_reg <= axi_rdata_i;
                        rsp_err_reg   <= |axi_rresp_i;
                        rsp_valid_reg <= 1'b1;
                        req_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o   = req_ready_reg;
    assign rsp_valid_o   = rsp_valid_reg;
    assign rsp_rdata_o   = rsp_rdata_reg;
    assign rsp_err_o     = rsp_err_reg;

    assign axi_awid_o    = ID_WIDTH'(AXI_ID);
    assign axi_awaddr_o  = addr_reg;
    assign axi_awlen_o   = '0;
    assign axi_awsize_o  = 3'(ADDR_OFFS);
    assign axi_awburst_o = 2'b01;
    assign axi_awlock_o  = 2'b00;
    assign axi_awcache_o = 4'b0000;
    assign axi_awprot_o  = 3'b000;
    assign axi_awqos_o   = 4'b0000;
    assign axi_awvalid_o = awvalid_reg;

    assign axi_wdata_o   = wdata_reg;
    assign axi_wstrb_o   = wstrb_reg;
    assign axi_wlast_o   = 1'b1;
    assign axi_wvalid_o  = wvalid_reg;
    assign axi_bready_o  = bready_reg;

    assign axi_arid_o    = ID_WIDTH'(AXI_ID);
    assign axi_araddr_o  = addr_reg;
    assign axi_arlen_o   = '0;
    assign axi_arsize_o  = 3'(ADDR_OFFS);
    assign axi_arburst_o = 2'b01;
    assign axi_arlock_o  = 2'b00;
    assign axi_arcache_o = 4'b0000;
    assign axi_arprot_o  = 3'b000;
    assign axi_arqos_o   = 4'b0000;
    assign axi_arvalid_o = arvalid_reg;
    assign axi_rready_o  = rready_reg;

endmodule

// File: tb/tb_axi_native_master.sv
// -----------------------------------------------------------------------------
// tb_axi_native_master
//
// Drives native requests into axi_native_master against a small AXI slave
// model (memory with byte strobes; addresses with bit 15 set answer SLVERR and
// ignore writes). Directed vectors come from a table, random traffic is
// checked against a word-array reference of the memory, and the multi-cycle
// corner cases run with hand-driven slave signals.
// -----------------------------------------------------------------------------
module tb_axi_native_master;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic [15:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic [3:0]  req_wstrb_i = '0;
    logic        req_ready_o;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [7:0]  axi_awid_o, axi_arid_o;
    logic [15:0] axi_awaddr_o, axi_araddr_o;
    logic [7:0]  axi_awlen_o, axi_arlen_o;
    logic [2:0]  axi_awsize_o, axi_arsize_o;
    logic [1:0]  axi_awburst_o, axi_arburst_o;
    logic [1:0]  axi_awlock_o, axi_arlock_o;
    logic [3:0]  axi_awcache_o, axi_arcache_o;
    logic [2:0]  axi_awprot_o, axi_arprot_o;
    logic [3:0]  axi_awqos_o, axi_arqos_o;
    logic        axi_awvalid_o, axi_arvalid_o;
    logic        axi_awready_i, axi_arready_i;
    logic [31:0] axi_wdata_o;
    logic [3:0]  axi_wstrb_o;
    logic        axi_wlast_o, axi_wvalid_o, axi_wready_i;
    logic [7:0]  axi_bid_i = 8'h5A;
    logic [7:0]  axi_rid_i = 8'hA5;
    logic [1:0]  axi_bresp_i, axi_rresp_i;
    logic        axi_bvalid_i, axi_bready_o;
    logic [31:0] axi_rdata_i;
    logic        axi_rlast_i, axi_rvalid_i, axi_rready_o;

    always #5 clk_i = ~clk_i;

    axi_native_master dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
        .req_ready_o(req_ready_o),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .axi_awid_o(axi_awid_o), .axi_awaddr_o(axi_awaddr_o), .axi_awlen_o(axi_awlen_o),
        .axi_awsize_o(axi_awsize_o), .axi_awburst_o(axi_awburst_o),
        .axi_awlock_o(axi_awlock_o), .axi_awcache_o(axi_awcache_o),
        .axi_awprot_o(axi_awprot_o), .axi_awqos_o(axi_awqos_o),
        .axi_awvalid_o(axi_awvalid_o), .axi_awready_i(axi_awready_i),
        .axi_wdata_o(axi_wdata_o), .axi_wstrb_o(axi_wstrb_o), .axi_wlast_o(axi_wlast_o),
        .axi_wvalid_o(axi_wvalid_o), .axi_wready_i(axi_wready_i),
        .axi_bid_i(axi_bid_i), .axi_bresp_i(axi_bresp_i),
        .axi_bvalid_i(axi_bvalid_i), .axi_bready_o(axi_bready_o),
        .axi_arid_o(axi_arid_o), .axi_araddr_o(axi_araddr_o), .axi_arlen_o(axi_arlen_o),
        .axi_arsize_o(axi_arsize_o), .axi_arburst_o(axi_arburst_o),
        .axi_arlock_o(axi_arlock_o), .axi_arcache_o(axi_arcache_o),
        .axi_arprot_o(axi_arprot_o), .axi_arqos_o(axi_arqos_o),
        .axi_arvalid_o(axi_arvalid_o), .axi_arready_i(axi_arready_i),
        .axi_rid_i(axi_rid_i), .axi_rdata_i(axi_rdata_i), .axi_rresp_i(axi_rresp_i),
        .axi_rlast_i(axi_rlast_i), .axi_rvalid_i(axi_rvalid_i), .axi_rready_o(axi_rready_o)
    );

    // ---------------- slave: automatic model or hand-driven ----------------
    logic        man = 1'b0;
    logic        rand_ready = 1'b0;
    logic        rand_lat = 1'b0;
    logic        m_awready = 1'b0, m_wready = 1'b0, m_arready = 1'b0;
    logic        m_bvalid = 1'b0, m_rvalid = 1'b0, m_rlast = 1'b0;
    logic [1:0]  m_bresp = 2'b00, m_rresp = 2'b00;
    logic [31:0] m_rdata = '0;
    logic        s_awready, s_wready, s_arready, s_bvalid, s_rvalid, s_rlast;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;

    assign axi_awready_i = man ? m_awready : s_awready;
    assign axi_wready_i  = man ? m_wready  : s_wready;
    assign axi_arready_i = man ? m_arready : s_arready;
    assign axi_bvalid_i  = man ? m_bvalid  : s_bvalid;
    assign axi_bresp_i   = man ? m_bresp   : s_bresp;
    assign axi_rvalid_i  = man ? m_rvalid  : s_rvalid;
    assign axi_rlast_i   = man ? m_rlast   : s_rlast;
    assign axi_rresp_i   = man ? m_rresp   : s_rresp;
    assign axi_rdata_i   = man ? m_rdata   : s_rdata;

    logic [31:0] s_mem [0:63];
    logic        aw_done, w_done, ar_done, junk_sent;
    logic [15:0] aw_addr_q, ar_addr_q, cur_awaddr, cur_araddr;
    logic [31:0] wd_q, cur_wdata;
    logic [3:0]  ws_q, cur_wstrb;
    logic        aw_now, w_now, ar_now;
    int          b_wait, r_wait;

    always @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 64; i++) s_mem[i] <= '0;
        end
        if (rst_i || man) begin
            s_awready <= 1'b0; s_wready <= 1'b0; s_arready <= 1'b0;
            s_bvalid <= 1'b0; s_rvalid <= 1'b0; s_rlast <= 1'b0;
            s_bresp <= 2'b00; s_rresp <= 2'b00; s_rdata <= '0;
            aw_done <= 1'b0; w_done <= 1'b0; ar_done <= 1'b0; junk_sent <= 1'b0;
            aw_addr_q <= '0; ar_addr_q <= '0; wd_q <= '0; ws_q <= '0;
            b_wait <= 0; r_wait <= 0;
        end else begin
            s_awready <= rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            s_wready  <= rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            s_arready <= rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;

            aw_now     = aw_done || (axi_awvalid_o && axi_awready_i);
            w_now      = w_done  || (axi_wvalid_o && axi_wready_i);
            ar_now     = ar_done || (axi_arvalid_o && axi_arready_i);
            cur_awaddr = aw_done ? aw_addr_q : axi_awaddr_o;
            cur_wdata  = w_done ? wd_q : axi_wdata_o;
            cur_wstrb  = w_done ? ws_q : axi_wstrb_o;
            cur_araddr = ar_done ? ar_addr_q : axi_araddr_o;

            if (axi_awvalid_o && axi_awready_i) begin aw_addr_q <= axi_awaddr_o; aw_done <= 1'b1; end
            if (axi_wvalid_o && axi_wready_i) begin wd_q <= axi_wdata_o; ws_q <= axi_wstrb_o; w_done <= 1'b1; end
            if (axi_arvalid_o && axi_arready_i) begin ar_addr_q <= axi_araddr_o; ar_done <= 1'b1; end

            if (s_bvalid && axi_bready_o) begin
                s_bvalid <= 1'b0;
                b_wait   <= rand_lat ? int'($urandom_range(0, 3)) : 0;
            end else if (aw_now && w_now && !s_bvalid) begin
                if (b_wait > 0) begin
                    b_wait <= b_wait - 1;
                end else begin
                    s_bvalid <= 1'b1;
                    s_bresp  <= cur_awaddr[15] ? 2'b10 : 2'b00;
                    if (!cur_awaddr[15])
                        for (int l = 0; l < 4; l++)
                            if (cur_wstrb[l]) s_mem[cur_awaddr[7:2]][8*l +: 8] <= cur_wdata[8*l +: 8];
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                end
            end

            if (s_rvalid && axi_rready_o) begin
                s_rvalid <= 1'b0;
                if (s_rlast) r_wait <= rand_lat ? int'($urandom_range(0, 3)) : 0;
            end else if (ar_now && !s_rvalid) begin
                if (r_wait > 0) begin
                    r_wait <= r_wait - 1;
                end else if (rand_lat && !junk_sent && $urandom_range(0, 3) == 0) begin
                    // stray non-last beat the master has to ignore
                    s_rvalid  <= 1'b1; s_rlast <= 1'b0; s_rresp <= 2'b11;
                    s_rdata   <= $urandom;
                    junk_sent <= 1'b1;
                    ar_addr_q <= cur_araddr; ar_done <= 1'b1;
                end else begin
                    s_rvalid  <= 1'b1; s_rlast <= 1'b1;
                    s_rresp   <= cur_araddr[15] ? 2'b10 : 2'b00;
                    s_rdata   <= s_mem[cur_araddr[7:2]];
                    ar_done   <= 1'b0; junk_sent <= 1'b0;
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    int checks = 0;
    int errors = 0;
    logic [31:0] model_mem [0:63];
    logic [31:0] last_rdata = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents a request and returns at the falling edge of the cycle after
    // acceptance, with req_valid_i already dropped.
    task automatic issue(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        int w = 0;
        @(negedge clk_i);
        req_valid_i = 1'b1; req_addr_i = a; req_wdata_i = d; req_wstrb_i = s;
        while (!req_ready_o && w < 50) begin @(negedge clk_i); w++; end
        chk("req_accept", {63'b0, req_ready_o}, 64'd1);
        @(negedge clk_i);
        req_valid_i = 1'b0; req_wstrb_i = '0;
        chk("ready_low_after_accept", {63'b0, req_ready_o}, 64'd0);
    endtask

    task automatic run_req(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [31:0] exp_rdata, input logic exp_err,
                           input bit check_lat, input string tag);
        int lat = 1;
        issue(a, d, s);
        while (!rsp_valid_o && lat < 200) begin @(negedge clk_i); lat++; end
        chk({tag, "_rsp_seen"}, {63'b0, rsp_valid_o}, 64'd1);
        chk({tag, "_err"}, {63'b0, rsp_err_o}, {63'b0, exp_err});
        chk({tag, "_rdata"}, {32'b0, rsp_rdata_o}, {32'b0, exp_rdata});
        chk({tag, "_ready_at_rsp"}, {63'b0, req_ready_o}, 64'd1);
        if (check_lat) chk({tag, "_latency"}, 64'(lat), 64'd3);
        $display("txn %s addr=%h wdata=%h strb=%h rdata=%h err=%0d lat=%0d",
                 tag, a, d, s, rsp_rdata_o, rsp_err_o, lat);
        @(negedge clk_i);
        chk({tag, "_pulse_one_cycle"}, {63'b0, rsp_valid_o}, 64'd0);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r = old;
        for (int l = 0; l < 4; l++) if (s[l]) r[8*l +: 8] = d[8*l +: 8];
        return r;
    endfunction

    typedef struct {
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        logic [31:0] d, e;
        logic [3:0]  s;

        for (int i = 0; i < 64; i++) model_mem[i] = '0;
        // write result keeps the previous read data
        tbl[0] = '{16'h0010, 32'hDEADBEEF, 4'hF, 32'h0000_0000, 1'b0};
        tbl[1] = '{16'h0010, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        tbl[2] = '{16'h0020, 32'h11223344, 4'hF, 32'hDEADBEEF, 1'b0};
        tbl[3] = '{16'h0020, 32'hAABBCCDD, 4'h2, 32'hDEADBEEF, 1'b0};
        tbl[4] = '{16'h0020, 32'h0,        4'h0, 32'h1122CC44, 1'b0};
        tbl[5] = '{16'h0013, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        tbl[6] = '{16'h8004, 32'h55555555, 4'hF, 32'hDEADBEEF, 1'b1};
        tbl[7] = '{16'h8004, 32'h0,        4'h0, 32'h0000_0000, 1'b1};
        tbl[8] = '{16'h00FC, 32'h01020304, 4'h9, 32'h0000_0000, 1'b0};
        tbl[9] = '{16'h00FE, 32'h0,        4'h0, 32'h01000004, 1'b0};

        // reset state
        repeat (3) @(negedge clk_i);
        chk("rst_ready", {63'b0, req_ready_o}, 64'd0);
        chk("rst_valids", {58'b0, axi_awvalid_o, axi_wvalid_o, axi_bready_o,
                           axi_arvalid_o, axi_rready_o, rsp_valid_o}, 64'd0);
        chk("rst_rsp", {31'b0, rsp_err_o, rsp_rdata_o}, 64'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("ready_after_rst", {63'b0, req_ready_o}, 64'd1);

        // directed table, zero-wait slave
        for (int i = 0; i < 10; i++) begin
            run_req(tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, tbl[i].exp_rdata, tbl[i].exp_err, 1, $sformatf("tbl%0d", i));
            if (tbl[i].wstrb != 0 && !tbl[i].addr[15])
                model_mem[tbl[i].addr[7:2]] = merge(model_mem[tbl[i].addr[7:2]], tbl[i].wdata, tbl[i].wstrb);
            if (tbl[i].wstrb == 0) last_rdata = tbl[i].exp_rdata;
        end

        // random traffic, random ready and response delays
        rand_ready = 1'b1; rand_lat = 1'b1;
        for (int t = 0; t < 40; t++) begin
            a = {($urandom_range(0, 7) == 0), 7'b0, 8'($urandom)};
            s = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            d = $urandom;
            if (s != 0) begin
                if (!a[15]) model_mem[a[7:2]] = merge(model_mem[a[7:2]], d, s);
                e = last_rdata;
            end else begin
                e = model_mem[a[7:2]];
                last_rdata = e;
            end
            run_req(a, d, s, e, a[15], 0, "rand");
        end
        rand_ready = 1'b0; rand_lat = 1'b0;

        // W held off for several cycles after the AW handshake
        man = 1'b1;
        issue(16'h0040, 32'hCAFEF00D, 4'hF);
        chk("aw_w_valid", {62'b0, axi_awvalid_o, axi_wvalid_o}, 64'd3);
        chk("aw_payload", {axi_awaddr_o, axi_wdata_o, axi_wstrb_o, axi_wlast_o}, {16'h0040, 32'hCAFEF00D, 4'hF, 1'b1});
        chk("aw_attr", {axi_awid_o, axi_awlen_o, axi_awsize_o, axi_awburst_o, axi_awlock_o,
                        axi_awcache_o, axi_awprot_o, axi_awqos_o}, {8'h0, 8'h0, 3'd2, 2'b01, 2'b0, 4'b0, 3'b0, 4'b0});
        m_awready = 1'b1;
        @(negedge clk_i);
        m_awready = 1'b0;
        chk("aw_drop_w_hold", {62'b0, axi_awvalid_o, axi_wvalid_o}, 64'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            chk("w_wait_state", {60'b0, axi_wvalid_o, axi_bready_o, rsp_valid_o, req_ready_o}, 64'b1000);
            chk("w_wait_data", {32'b0, axi_wdata_o}, {32'b0, 32'hCAFEF00D});
        end
        m_wready = 1'b1;
        @(negedge clk_i);
        m_wready = 1'b0;
        chk("w_done_bready", {62'b0, axi_wvalid_o, axi_bready_o}, 64'd1);
        m_bvalid = 1'b1; m_bresp = 2'b00;
        @(negedge clk_i);
        m_bvalid = 1'b0;
        chk("hold_rsp", {61'b0, rsp_valid_o, rsp_err_o, req_ready_o}, 64'b101);
        chk("hold_rdata", {32'b0, rsp_rdata_o}, {32'b0, last_rdata});
        @(negedge clk_i);
        chk("hold_single_pulse", {63'b0, rsp_valid_o}, 64'd0);
        $display("txn hold addr=0040 wdata=cafef00d strb=f");

        // W before AW, then error response after a B stall
        issue(16'h0050, 32'h12345678, 4'hF);
        m_wready = 1'b1;
        @(negedge clk_i);
        m_wready = 1'b0;
        chk("w_first", {61'b0, axi_awvalid_o, axi_wvalid_o, axi_bready_o}, 64'b100);
        m_awready = 1'b1;
        @(negedge clk_i);
        m_awready = 1'b0;
        chk("aw_second", {62'b0, axi_awvalid_o, axi_bready_o}, 64'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            chk("b_stall", {61'b0, req_ready_o, rsp_valid_o, axi_bready_o}, 64'b001);
        end
        m_bvalid = 1'b1; m_bresp = 2'b10;
        @(negedge clk_i);
        m_bvalid = 1'b0; m_bresp = 2'b00;
        chk("slverr_rsp", {61'b0, rsp_valid_o, rsp_err_o, req_ready_o}, 64'b111);
        chk("slverr_rdata", {32'b0, rsp_rdata_o}, {32'b0, last_rdata});
        @(negedge clk_i);
        chk("slverr_held", {62'b0, rsp_valid_o, rsp_err_o}, 64'd1);
        $display("txn slverr addr=0050 wdata=12345678 strb=f");

        // unaligned read, stray beat, then reset in RD_DATA
        issue(16'h0013, 32'h0, 4'h0);
        chk("ar_valid", {62'b0, axi_arvalid_o, axi_awvalid_o}, 64'b10);
        chk("ar_addr", {48'b0, axi_araddr_o}, 64'h0010);
        chk("ar_attr", {axi_arid_o, axi_arlen_o, axi_arsize_o, axi_arburst_o, axi_arlock_o,
                        axi_arcache_o, axi_arprot_o, axi_arqos_o}, {8'h0, 8'h0, 3'd2, 2'b01, 2'b0, 4'b0, 3'b0, 4'b0});
        m_arready = 1'b1;
        @(negedge clk_i);
        m_arready = 1'b0;
        chk("ar_done_rready", {62'b0, axi_arvalid_o, axi_rready_o}, 64'd1);
        m_rvalid = 1'b1; m_rlast = 1'b0; m_rdata = 32'hBAD0BAD0; m_rresp = 2'b11;
        @(negedge clk_i);
        m_rvalid = 1'b0;
        chk("stray_beat_ignored", {62'b0, rsp_valid_o, axi_rready_o}, 64'd1);
        rst_i = 1'b1;
        m_rvalid = 1'b1; m_rlast = 1'b1; m_rresp = 2'b00;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            chk("midrst_outputs", {57'b0, req_ready_o, axi_awvalid_o, axi_wvalid_o, axi_bready_o,
                                   axi_arvalid_o, axi_rready_o, rsp_valid_o}, 64'd0);
            chk("midrst_rsp", {31'b0, rsp_err_o, rsp_rdata_o}, 64'd0);
        end
        m_rvalid = 1'b0; m_rlast = 1'b0;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("post_rst", {62'b0, req_ready_o, rsp_valid_o}, 64'b10);
        $display("txn midrst addr=0013 araddr=0010");

        // memory was cleared by the reset
        for (int i = 0; i < 64; i++) model_mem[i] = '0;
        last_rdata = '0;
        man = 1'b0;
        run_req(16'h0010, 32'h0, 4'h0, model_mem[4], 1'b0, 1, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_native_master.md
AXI_NATIVE_MASTER -- requirements
Module: axi_native_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning AXI and native data width in bits (power of two, at least 8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, meaning byte-address width.
REQ-003 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, meaning byte-strobe width.
REQ-004 SHALL have parameter ID_WIDTH, default 8, meaning AXI ID width.
REQ-005 SHALL have parameter LEN_WIDTH, default 8, meaning AXI burst-length width.
REQ-006 SHALL have parameter AXI_ID, default 0, meaning constant driven on axi_awid_o and axi_arid_o.
REQ-007 SHALL have one clock and a synchronous, active-high reset: clk_i  in  1  clock; rst_i  in  1  reset.
REQ-008 SHALL have these native request ports:
- req_valid_i  in  1  request valid.
- req_addr_i  in  ADDR_WIDTH  byte address.
- req_wdata_i  in  DATA_WIDTH  write data.
- req_wstrb_i  in  STRB_WIDTH  byte strobes; non-zero means write, zero means read.
- req_ready_o  out  1  request accepted when high together with req_valid_i.
REQ-009 SHALL have these native response ports:
- rsp_valid_o  out  1  single-cycle response pulse.
- rsp_rdata_o  out  DATA_WIDTH  read data.
- rsp_err_o  out  1  error response, high when bresp or rresp is non-zero.
REQ-010 SHALL have these AXI write-address ports:
- axi_awid_o  out  ID_WIDTH  write ID.
- axi_awaddr_o  out  ADDR_WIDTH  write address.
- axi_awlen_o  out  LEN_WIDTH  burst length.
- axi_awsize_o  out  3  beat size.
- axi_awburst_o  out  2  burst type.
- axi_awlock_o  out  2  lock.
- axi_awcache_o  out  4  cache.
- axi_awprot_o  out  3  protection.
- axi_awqos_o  out  4  QoS.
- axi_awvalid_o  out  1  valid.
- axi_awready_i  in  1  ready.
REQ-011 SHALL have these AXI write-data and write-response ports:
- axi_wdata_o  out  DATA_WIDTH  write data.
- axi_wstrb_o  out  STRB_WIDTH  write strobes.
- axi_wlast_o  out  1  last beat.
- axi_wvalid_o  out  1  valid.
- axi_wready_i  in  1  ready.
- axi_bid_i  in  ID_WIDTH  response ID.
- axi_bresp_i  in  2  response code.
- axi_bvalid_i  in  1  valid.
- axi_bready_o  out  1  ready.
REQ-012 SHALL have AR ports mirroring the AW ports with the ar prefix.
REQ-013 SHALL have these AXI read-data ports:
- axi_rid_i  in  ID_WIDTH  read ID.
- axi_rdata_i  in  DATA_WIDTH  read data.
- axi_rresp_i  in  2  response code.
- axi_rlast_i  in  1  last beat.
- axi_rvalid_i  in  1  valid.
- axi_rready_o  out  1  ready.

Function
REQ-014 SHALL hold at most one transaction outstanding, using states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR and RD_DATA.
REQ-015 SHALL register all outputs; no combinational path SHALL exist from any input to any output.
REQ-016 SHALL drive req_ready_o high only in IDLE and low in the cycle after acceptance.
REQ-017 SHALL, on acceptance with req_wstrb_i non-zero, move to WR_ADDR_DATA and raise axi_awvalid_o and axi_wvalid_o in the next cycle.
REQ-018 SHALL, on acceptance with req_wstrb_i zero, move to RD_ADDR and raise axi_arvalid_o in the next cycle.
REQ-019 SHALL latch address, data and strobes at acceptance and hold all AXI payloads stable while the corresponding valid is high.
REQ-020 SHALL drive the address as req_addr_i with the low $clog2(STRB_WIDTH) bits forced to zero.
REQ-021 SHALL drive these fixed burst fields on both AW and AR:
- len = 0.
- size = $clog2(STRB_WIDTH).
- burst = 2'b01 (INCR).
REQ-022 SHALL drive lock, cache, prot and qos as zero, and axi_wlast_o as 1.
REQ-023 SHALL, in WR_ADDR_DATA, deassert axi_awvalid_o and axi_wvalid_o independently the cycle after their own handshake.
REQ-024 SHALL handle AW and W handshakes arriving in either order or the same cycle.
REQ-025 SHALL enter WR_RESP once both AW and W handshakes have completed, asserting axi_bready_o.
REQ-026 SHALL, in WR_RESP on axi_bvalid_i, do all of the following:
- pulse rsp_valid_o for exactly one cycle.
- set rsp_err_o = (axi_bresp_i != 0).
- hold rsp_rdata_o unchanged.
- return to IDLE with req_ready_o high in the same cycle as the pulse.
REQ-027 SHALL, in RD_ADDR, deassert axi_arvalid_o after the AR handshake, enter RD_DATA and assert axi_rready_o.
REQ-028 SHALL, in RD_DATA on axi_rvalid_i && axi_rlast_i, do all of the following:
- capture axi_rdata_i into rsp_rdata_o.
- set rsp_err_o = (axi_rresp_i != 0).
- pulse rsp_valid_o.
- return to IDLE.
REQ-029 SHALL ignore R beats without rlast, which are not expected since len = 0.
REQ-030 SHALL ignore bid and rid.
REQ-031 SHALL hold the response fields until the next response; rsp_valid_o has no backpressure.
REQ-032 SHALL give minimum latency from acceptance (cycle N) to rsp_valid_o as follows, with a zero-wait slave that returns B or R one cycle after handshake:
- write: N+3.
- read: N+3.

Reset
REQ-033 SHALL reset to the following values when rst_i is high at a clock edge:
- state = IDLE.
- req_ready_o = 0, rising to 1 the cycle after reset is released.
- all AXI valid/ready outputs = 0.
- rsp_valid_o = 0.
- rsp_err_o = 0.
- rsp_rdata_o = 0.
REQ-034 SHALL abandon any in-flight transaction when reset is asserted mid-transaction, producing no response pulse.
REQ-035 SHALL keep all outputs at their reset values for as long as rst_i is held.

Verification
REQ-036 Write then read back: write 0xDEADBEEF at 0x0010 with strb 0xF, then read 0x0010 -> one write pulse with err=0, then read pulse with rdata=0xDEADBEEF and err=0.
REQ-037 Partial write: write 0x11223344 strb 0xF, then 0xAABBCCDD strb 0x2 at 0x0020, then read -> rdata=0x1122CC44.
REQ-038 AW/W ordering: slave holds wready low 5 cycles after the AW handshake -> axi_wvalid_o stays high, no bready before the W handshake, exactly one response.
REQ-039 Error and back-pressure: slave returns bresp=2'b10 after 3 cycles of bvalid=0 -> rsp_err_o=1 and req_ready_o low until the pulse.
REQ-040 Unaligned address and reset: read 0x0013 -> axi_araddr_o=0x0010; rst_i asserted while in RD_DATA -> no rsp_valid_o pulse and all valids 0 the next cycle.
